// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bcd_pkg;
   localparam int BCD_WIDTH       = 32;
   localparam int BCD_DIGITS      = 10;
   localparam int BCD_DISP_DIGITS = 7;

   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_OFFSET = 4'd3;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_SHIFT = 2'd1;
   localparam state_t S_DONE  = 2'd2;
endpackage

// File: rtl/bcd_adjust_nibble.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module bcd_adjust_nibble
   import bcd_pkg::*;
(
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);
   // Input never exceeds 9, so the 4-bit sum cannot wrap.
   assign q_o = (d_i >= ADJ_THRESH) ? d_i + ADJ_OFFSET : d_i;
endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with valid/ready handshakes on both sides.
module bcd_convert_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH       = BCD_WIDTH,
   parameter int DIGITS      = BCD_DIGITS,
   parameter int DISP_DIGITS = BCD_DISP_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_neg,
   output logic [3:0]            out_digits,
   output logic                  out_ovf
);
   localparam int         CW     = $clog2(WIDTH + 1);
   localparam logic [3:0] DISP_L = 4'(DISP_DIGITS);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    bin_q, bin_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                neg_q, neg_d;
   logic [3:0]          dig_q, dig_d;
   logic                ovf_q, ovf_d;

   logic [4*DIGITS-1:0] bcd_adj, bcd_nxt;
   logic [WIDTH-1:0]    bin_nxt, mag;
   logic                in_neg;
   logic [3:0]          dig_cnt;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adjust_nibble u_adj (
         .d_i (bcd_q[4*g +: 4]),
         .q_o (bcd_adj[4*g +: 4])
      );
   end

   assign {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;

   assign in_neg = in_signed & in_data[WIDTH-1];
   assign mag    = in_neg ? -in_data : in_data;

   // Digit count looks at the post-shift value so it is ready on the final edge.
   always_comb begin
      dig_cnt = 4'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_nxt[4*i +: 4] != 4'd0) dig_cnt = 4'(i + 1);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      dig_d   = dig_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               bin_d   = mag;
               bcd_d   = '0;
               neg_d   = in_neg;
               cnt_d   = CW'(WIDTH);
               dig_d   = 4'd0;
               ovf_d   = 1'b0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bin_d = bin_nxt;
            bcd_d = bcd_nxt;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               dig_d   = dig_cnt;
               ovf_d   = dig_cnt > DISP_L;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         dig_q   <= 4'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         dig_q   <= dig_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_bcd    = bcd_q;
   assign out_neg    = neg_q;
   assign out_digits = dig_q;
   assign out_ovf    = ovf_q;
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Randomized bench for bcd_convert_seq against a decimal arithmetic reference.
module tb_bcd_convert_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_signed;
   logic [31:0] in_data;
   logic        out_valid, out_ready, out_neg, out_ovf;
   logic [39:0] out_bcd;
   logic [3:0]  out_digits;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_convert_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_signed  (in_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bcd    (out_bcd),
      .out_neg    (out_neg),
      .out_digits (out_digits),
      .out_ovf    (out_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] ref_bcd(input longint unsigned m);
      logic [39:0] r;
      r = '0;
      for (int i = 0; i < 10; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic int ref_digits(input longint unsigned m);
      int n;
      n = 1;
      while (m >= 10) begin
         m = m / 10;
         n++;
      end
      return n;
   endfunction

   // Called and returns just after a falling edge. With ovl set, the next
   // input (od/os) is presented throughout the stall and across the handshake.
   task automatic do_conv(input logic [31:0] d, input logic s, input int stall,
                          input logic ovl, input logic [31:0] od, input logic os);
      longint unsigned m;
      logic [39:0]     eb;
      int              ed;
      int              n;
      logic            en;
      en = s && d[31];
      m  = en ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
      eb = ref_bcd(m);
      ed = ref_digits(m);
      chk("in_ready_idle", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = d;
      in_signed = s;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      in_data   = $urandom;
      in_signed = 1'($urandom_range(0, 1));
      chk("in_ready_busy", in_ready, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, 32);
      chk("bcd", out_bcd, eb);
      chk("neg", out_neg, en);
      chk("digits", out_digits, ed);
      chk("ovf", out_ovf, ed > 7);
      if (ovl) begin
         in_valid  = 1'b1;
         in_data   = od;
         in_signed = os;
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_bcd", out_bcd, eb);
         chk("stall_digits", out_digits, ed);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hs_valid_low", out_valid, 0);
      chk("hs_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [31:0] rd;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_signed = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bcd", out_bcd, 0);
      chk("rst_digits", out_digits, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      do_conv(32'd0,          1'b0, 0, 1'b0, 0, 0);
      do_conv(32'hFFFF_FFFF,  1'b0, 1, 1'b0, 0, 0);
      do_conv(32'hFFFF_FFFF,  1'b1, 0, 1'b0, 0, 0);
      do_conv(32'h8000_0000,  1'b1, 2, 1'b0, 0, 0);
      do_conv(32'h8000_0000,  1'b0, 0, 1'b0, 0, 0);
      do_conv(32'd9999999,    1'b0, 0, 1'b0, 0, 0);
      do_conv(32'd10000000,   1'b0, 0, 1'b0, 0, 0);
      do_conv(32'd5,          1'b1, 0, 1'b0, 0, 0);

      // Backpressure with a new input waiting across the handshake edge.
      do_conv(32'd4096,       1'b0, 5, 1'b1, 32'hFFFF_FC18, 1'b1);
      do_conv(32'hFFFF_FC18,  1'b1, 0, 1'b0, 0, 0);

      // Asynchronous reset at shift iteration 10.
      chk("pre_rst_ready", in_ready, 1);
      in_valid  = 1'b1;
      in_data   = 32'd987654321;
      in_signed = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_valid", out_valid, 0);
      chk("arst_bcd", out_bcd, 0);
      chk("arst_neg", out_neg, 0);
      chk("arst_digits", out_digits, 0);
      chk("arst_ovf", out_ovf, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      do_conv(32'd12345, 1'b0, 0, 1'b0, 0, 0);

      for (int k = 0; k < 25; k++) begin
         rd = $urandom >> $urandom_range(0, 31);
         do_conv(rd, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
